// File: rtl/digit_serial_pkg.sv
// Shared types and default sizing for the digit-serial adder sequencer.
package digit_serial_pkg;

  localparam int unsigned DefaultDigitW  = 4;
  localparam int unsigned DefaultNDigits = 4;

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StRun,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/digit_shift_reg.sv
// Word register that loads in parallel or shifts right by one digit,
// inserting a new digit at the MSB side.
module digit_shift_reg #(
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned WORD_W   = DIGIT_W * N_DIGITS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_value,
  input  logic              shift,
  input  logic [DIGIT_W-1:0] shift_in,
  output logic [WORD_W-1:0] value
);

  logic [WORD_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (shift) begin
      value_d = {shift_in, value_q[WORD_W-1:DIGIT_W]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/digit_serial_add_ctrl.sv
// Sequencer that feeds two word-wide operand pairs LSB-digit-first through an
// external dual-lane registered digit adder and reassembles the two results.
module digit_serial_add_ctrl
  import digit_serial_pkg::*;
#(
  parameter int unsigned DIGIT_W  = DefaultDigitW,
  parameter int unsigned N_DIGITS = DefaultNDigits,
  parameter int unsigned WORD_W   = DIGIT_W * N_DIGITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_a,
  input  logic [WORD_W-1:0]  in_b,
  input  logic [WORD_W-1:0]  in_a_2,
  input  logic [WORD_W-1:0]  in_b_2,
  output logic               add_start,
  output logic [DIGIT_W-1:0] add_a,
  output logic [DIGIT_W-1:0] add_b,
  output logic [DIGIT_W-1:0] add_a_2,
  output logic [DIGIT_W-1:0] add_b_2,
  input  logic [DIGIT_W-1:0] add_out,
  input  logic [DIGIT_W-1:0] add_out_2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_sum,
  output logic [WORD_W-1:0]  out_sum_2
);

  localparam int unsigned CntW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N_DIGITS - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept, op_shift, res_shift;

  logic [WORD_W-1:0] a_word, b_word, a2_word, b2_word;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    op_shift  = 1'b0;
    res_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = StPrime;
        end
      end
      StPrime: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        op_shift  = 1'b1;
        // Adder output lags its inputs by one cycle, so digit k-1 arrives in step k.
        res_shift = (cnt_q != '0);
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFlush: begin
        res_shift = 1'b1;
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign add_start = (state_q == StPrime);

  assign add_a   = (state_q == StRun) ? a_word[DIGIT_W-1:0]  : '0;
  assign add_b   = (state_q == StRun) ? b_word[DIGIT_W-1:0]  : '0;
  assign add_a_2 = (state_q == StRun) ? a2_word[DIGIT_W-1:0] : '0;
  assign add_b_2 = (state_q == StRun) ? b2_word[DIGIT_W-1:0] : '0;

  digit_shift_reg #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS), .WORD_W(WORD_W)) u_op_a (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (in_a),
    .shift      (op_shift),
    .shift_in   ({DIGIT_W{1'b0}}),
    .value      (a_word)
  );

  digit_shift_reg #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS), .WORD_W(WORD_W)) u_op_b (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (in_b),
    .shift      (op_shift),
    .shift_in   ({DIGIT_W{1'b0}}),
    .value      (b_word)
  );

  digit_shift_reg #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS), .WORD_W(WORD_W)) u_op_a_2 (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (in_a_2),
    .shift      (op_shift),
    .shift_in   ({DIGIT_W{1'b0}}),
    .value      (a2_word)
  );

  digit_shift_reg #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS), .WORD_W(WORD_W)) u_op_b_2 (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (in_b_2),
    .shift      (op_shift),
    .shift_in   ({DIGIT_W{1'b0}}),
    .value      (b2_word)
  );

  digit_shift_reg #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS), .WORD_W(WORD_W)) u_res (
    .clock      (clock),
    .reset      (reset),
    .load       (1'b0),
    .load_value ({WORD_W{1'b0}}),
    .shift      (res_shift),
    .shift_in   (add_out),
    .value      (out_sum)
  );

  digit_shift_reg #(.DIGIT_W(DIGIT_W), .N_DIGITS(N_DIGITS), .WORD_W(WORD_W)) u_res_2 (
    .clock      (clock),
    .reset      (reset),
    .load       (1'b0),
    .load_value ({WORD_W{1'b0}}),
    .shift      (res_shift),
    .shift_in   (add_out_2),
    .value      (out_sum_2)
  );

endmodule

// File: tb/tb_digit_serial_add_ctrl.sv
// Directed bench for digit_serial_add_ctrl with a behavioural model of the
// dual-lane registered carry-chain adder attached to its digit buses.
module tb_digit_serial_add_ctrl;

  localparam int unsigned DW = 4;
  localparam int unsigned ND = 4;
  localparam int unsigned WW = DW * ND;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] in_a = '0, in_b = '0, in_a_2 = '0, in_b_2 = '0;
  logic          add_start;
  logic [DW-1:0] add_a, add_b, add_a_2, add_b_2;
  logic [DW-1:0] add_out, add_out_2;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_sum, out_sum_2;

  int checks = 0;
  int errors = 0;

  // Adder model: start seeds carry with the negate setting, otherwise one
  // registered digit step per clock.
  logic          neg_1 = 1'b0, neg_2 = 1'b0;
  logic          carry_1, carry_2;

  function automatic logic [DW:0] dig_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic neg, input logic c);
    logic [DW-1:0] bm;
    bm = neg ? ~b : b;
    return {1'b0, a} + {1'b0, bm} + {{DW{1'b0}}, c};
  endfunction

  always @(posedge clock) begin
    if (add_start) begin
      carry_1 <= neg_1;
      carry_2 <= neg_2;
    end else begin
      {carry_1, add_out}   <= dig_add(add_a, add_b, neg_1, carry_1);
      {carry_2, add_out_2} <= dig_add(add_a_2, add_b_2, neg_2, carry_2);
    end
  end

  digit_serial_add_ctrl #(.DIGIT_W(DW), .N_DIGITS(ND)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_a_2    (in_a_2),
    .in_b_2    (in_b_2),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_a_2   (add_a_2),
    .add_b_2   (add_b_2),
    .add_out   (add_out),
    .add_out_2 (add_out_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sum_2 (out_sum_2)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands in IDLE and take the accept edge; leaves the DUT in PRIME.
  task automatic start_op(input logic [WW-1:0] a, input logic [WW-1:0] b,
                          input logic [WW-1:0] a2, input logic [WW-1:0] b2);
    in_a = a; in_b = b; in_a_2 = a2; in_b_2 = b2;
    in_valid = 1'b1;
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_a = 16'hDEAD; in_b = 16'hBEEF; in_a_2 = 16'h5A5A; in_b_2 = 16'hA5A5;
  endtask

  // From PRIME onward: check strobe, first digit, latency and results; ends in DONE.
  task automatic complete_op(input string tag, input logic [WW-1:0] a, input logic [WW-1:0] b2,
                             input logic [WW-1:0] exp1, input logic [WW-1:0] exp2);
    int lat;
    check({tag, "_prime_start"}, {31'd0, add_start}, 32'd1);
    check({tag, "_prime_bus"}, {28'd0, add_a}, 32'd0);
    tick();
    check({tag, "_run0_start"}, {31'd0, add_start}, 32'd0);
    check({tag, "_run0_a"}, {28'd0, add_a}, {28'd0, a[3:0]});
    check({tag, "_run0_b2"}, {28'd0, add_b_2}, {28'd0, b2[3:0]});
    lat = 2;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd7);
    check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, exp1});
    check({tag, "_sum_2"}, {16'd0, out_sum_2}, {16'd0, exp2});
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_release_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [WW-1:0] bb_a [3];
  logic [WW-1:0] bb_b [3];
  logic [WW-1:0] bb_e [3];
  int            acc_cyc [3];

  initial begin
    // Reset state while reset is held.
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_add_start", {31'd0, add_start}, 32'd0);
    check("rst_buses", {16'd0, add_a, add_b, add_a_2, add_b_2}, 32'd0);
    check("rst_sums", {out_sum, out_sum_2}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Addition.
    start_op(16'h1234, 16'h0FFF, 16'h0001, 16'h0002);
    complete_op("add", 16'h1234, 16'h0002, 16'h2233, 16'h0003);
    out_ready = 1'b1;  // early assertion would have had no effect; now release
    tick();
    out_ready = 1'b0;
    check("add_release_valid", {31'd0, out_valid}, 32'd0);

    // Wrap-around; carry-out discarded.
    start_op(16'hFFFF, 16'h0001, 16'h8000, 16'h8000);
    complete_op("wrap", 16'hFFFF, 16'h8000, 16'h0000, 16'h0000);
    release_op("wrap");

    // Subtraction through adder negate settings.
    neg_1 = 1'b1; neg_2 = 1'b1;
    start_op(16'h1234, 16'h0FFF, 16'h0000, 16'h0001);
    complete_op("sub", 16'h1234, 16'h0001, 16'h0235, 16'hFFFF);

    // Backpressure: hold in DONE for 10 cycles with a competing request pending.
    neg_1 = 1'b0; neg_2 = 1'b0;
    in_a = 16'h0101; in_b = 16'h0202; in_a_2 = 16'h0010; in_b_2 = 16'h0020;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_no_start", {31'd0, add_start}, 32'd0);
      check("bp_hold", {out_sum, out_sum_2}, {16'h0235, 16'hFFFF});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    complete_op("bp_next", 16'h0101, 16'h0020, 16'h0303, 16'h0030);
    release_op("bp_next");

    // Back-to-back with both handshakes held high.
    bb_a[0] = 16'h1111; bb_b[0] = 16'h2222; bb_e[0] = 16'h3333;
    bb_a[1] = 16'h00FF; bb_b[1] = 16'h0001; bb_e[1] = 16'h0100;
    bb_a[2] = 16'hABCD; bb_b[2] = 16'h1000; bb_e[2] = 16'hBBCD;
    begin
      int cyc;
      int acc;
      int res;
      cyc = 0; acc = 0; res = 0;
      out_ready = 1'b1;
      in_a = bb_a[0]; in_b = bb_b[0]; in_a_2 = bb_b[0]; in_b_2 = bb_a[0];
      in_valid = 1'b1;
      while (res < 3 && cyc < 60) begin
        if (out_valid) begin
          check("b2b_sum", {16'd0, out_sum}, {16'd0, bb_e[res]});
          check("b2b_sum_2", {16'd0, out_sum_2}, {16'd0, bb_e[res]});
          res++;
        end
        if (in_ready && in_valid && acc < 3) begin
          acc_cyc[acc] = cyc;
          acc++;
        end
        tick();
        cyc++;
        if (acc < 3) begin
          in_a = bb_a[acc]; in_b = bb_b[acc]; in_a_2 = bb_b[acc]; in_b_2 = bb_a[acc];
        end else begin
          in_valid = 1'b0;
        end
      end
      check("b2b_results", res, 32'd3);
      check("b2b_accepts", acc, 32'd3);
      check("b2b_gap_1", acc_cyc[1] - acc_cyc[0], 32'd8);
      check("b2b_gap_2", acc_cyc[2] - acc_cyc[1], 32'd8);
      out_ready = 1'b0;
      in_valid = 1'b0;
    end
    tick();

    // Reset during RUN k=2 of a subtraction, then a fresh add.
    neg_1 = 1'b1; neg_2 = 1'b1;
    start_op(16'hFFFF, 16'h0000, 16'hEEEE, 16'h0000);
    tick();  // RUN k=0
    tick();  // RUN k=1
    tick();  // RUN k=2
    check("mid_run_bus", {28'd0, add_a}, 32'hF);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_buses", {16'd0, add_a, add_b, add_a_2, add_b_2}, 32'd0);
    check("mid_rst_sums", {out_sum, out_sum_2}, 32'd0);
    tick();
    reset = 1'b0;
    neg_1 = 1'b0; neg_2 = 1'b0;
    tick();
    start_op(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    complete_op("post_rst", 16'h0001, 16'h0001, 16'h0002, 16'h0002);
    release_op("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_add_ctrl.md
Name: digit_serial_add_ctrl

Overview:
- Sequencer for the dual-lane 4-bit carry-chain adder block: accepts two WORD_W-bit operand pairs over a valid/ready handshake.
- Slices the operands LSB-digit-first onto the adder's digit buses and asserts the adder's start strobe to seed its carry registers.
- Reassembles the registered digit outputs into two WORD_W-bit results, presented on a valid/ready output handshake.
- The adder is instantiated alongside, not inside, this block; its negate parameters set add vs subtract.

Parameters:
- DIGIT_W, 4: digit width; must match the adder's lane width.
- N_DIGITS, 4: digits per word; N_DIGITS >= 2.
- WORD_W, DIGIT_W*N_DIGITS: operand/result width (derived; not overridden).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  operand pairs valid.
- in_ready  out  1  block can accept operands.
- in_a, in_b  in  WORD_W  lane-1 operands (upper adder lane).
- in_a_2, in_b_2  in  WORD_W  lane-2 operands (lower adder lane).
- add_start  out  1  to adder io_start.
- add_a, add_b, add_a_2, add_b_2  out  DIGIT_W each  to adder io_a, io_b, io_a_2, io_b_2.
- add_out, add_out_2  in  DIGIT_W each  from adder io_out, io_out_2 (registered in adder).
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- out_sum, out_sum_2  out  WORD_W each  reassembled lane results.

Behaviour:
- Clock/reset: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE, in_ready=1, out_valid=0, add_start=0, add_* digit buses=0, out_sum/out_sum_2=0, digit counter=0.
- FSM states: IDLE, PRIME, RUN, FLUSH, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch all four operands into shift registers and go to PRIME.
- PRIME (1 cycle): add_start=1, digit buses=0. The adder loads carry = neg param on this edge.
- RUN (N_DIGITS cycles, k=0..N_DIGITS-1): drive digit k (bits k*DIGIT_W +: DIGIT_W) of each operand; add_start=0.
  - Shift operands right by DIGIT_W each cycle.
  - From k>=1, capture add_out/add_out_2 as result digit k-1.
  - Counter wraps to 0 after k=N_DIGITS-1; go to FLUSH.
- FLUSH (1 cycle): digit buses=0; capture result digit N_DIGITS-1; go to DONE.
- DONE: out_valid=1 and results held stable. On out_ready, go to IDLE and drop out_valid the next cycle.
- Result capture: shift-in from the MSB side so digit 0 lands in bits [DIGIT_W-1:0] after the final capture.
- Latency: accept edge at cycle 0 -> out_valid high in cycle N_DIGITS+3 (cycle 7 for defaults).
  - Minimum initiation interval: N_DIGITS+4 cycles, with out_ready tied high.
- Arithmetic: results are modulo 2^WORD_W; the final carry-out is discarded.
  - Subtraction (adder neg param=1) yields a - b mod 2^WORD_W. The controller is agnostic to this.
- Adder carry state is never assumed from reset; every operation begins with PRIME.
- Boundaries:
  - in_valid while not IDLE: ignored, since in_ready=0; operands not sampled.
  - out_ready asserted before DONE: no effect.
  - in_valid held high across DONE->IDLE: accepted in the IDLE cycle, not the DONE cycle.
  - reset mid-operation: immediate return to reset values; partial results discarded; the in-flight adder output is ignored.
  - In-operation input changes: in_* changes after acceptance have no effect.

Decomposition:
- Shared package digit_serial_pkg: state enum (IDLE, PRIME, RUN, FLUSH, DONE) and default DIGIT_W/N_DIGITS constants.
- One natural sub-module: digit_shift_reg, a parameterised WORD_W load/shift-by-DIGIT_W register.
  - Used 4x for operand serialisation (load, shift right).
  - Used 2x for result deserialisation (shift-in at MSB).

Test Plan:
- Add, neg params 0, in_a=0x1234, in_b=0x0FFF, in_a_2=0x0001, in_b_2=0x0002 -> out_sum=0x2233, out_sum_2=0x0003; out_valid first high exactly 7 cycles after accept.
- Wrap: in_a=0xFFFF, in_b=0x0001, in_a_2=0x8000, in_b_2=0x8000 -> out_sum=0x0000, out_sum_2=0x0000.
- Subtract (adder neg_io_b=1, neg_io_b_2=1): in_a=0x1234, in_b=0x0FFF -> 0x0235; in_a_2=0x0000, in_b_2=0x0001 -> 0xFFFF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, results stable, in_ready=0, and a new in_valid is ignored. Release -> next operation accepted the cycle after.
- Back-to-back with out_ready=1 and in_valid=1 on 3 operand sets -> accepts spaced 8 cycles apart; all three results correct.
- Assert reset during RUN k=2, then run 0x0001+0x0001 -> outputs at reset values immediately; following result 0x0002 (carry re-seeded by PRIME).
